seq_shift_unit: RTL
===================

# seq_shift_unit

Parametrised multi-cycle shifter for the ALU datapath. It accepts an operand, a shift mode and a shift amount on a start strobe, then shifts one bit position per clock. It signals completion with a one-cycle done pulse, and presents the result and the last bit shifted out. It extends the ALU's plain load-enable register with real shift and rotate modes, a busy/done handshake and carry-out.

## Interface
- DATA_LENGTH, 12: operand/result width in bits (≥ 2).
- SHAMT_W, $clog2(DATA_LENGTH): width of the shift-amount port. With the default, this is 4 and amounts 0–15 are legal.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101–111 reserved.
- amount  in  SHAMT_W  number of single-bit shift steps.
- data_in  in  DATA_LENGTH  operand.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.
- data_out  out  DATA_LENGTH  working/result register.
- carry_out  out  1  last bit shifted or rotated out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, capture data_in into data_out, and capture mode and amount internally (cnt=amount).
  - Clear carry_out and go to SHIFT.
  - On start=0, hold all outputs.
- SHIFT:
  - If cnt==0, go to DONE with no shift.
  - Otherwise perform one step per cycle and decrement cnt.
- One step, per mode:
  - LSL: data_out={data_out[DATA_LENGTH-2:0],1'b0}; carry_out=old MSB.
  - LSR: data_out={1'b0,data_out[DATA_LENGTH-1:1]}; carry_out=old LSB.
  - ASR: as LSR, but the MSB is replicated into the vacated bit.
  - ROL: the old MSB moves to the LSB; carry_out=old MSB.
  - ROR: the old LSB moves to the MSB; carry_out=old LSB.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Reserved modes: treated as amount 0. The result is data_in unchanged, carry_out=0, and done follows with normal latency.
- Amounts ≥ DATA_LENGTH are stepped literally:
  - LSL/LSR yield 0.
  - ASR yields all sign bits.
  - Rotates wrap (ROR by 13 on 12 bits equals ROR by 1).
- start in SHIFT or DONE is ignored and not queued.
- mode, amount and data_in are don't-care after capture.
- data_out and carry_out hold their final values from DONE until the next accepted start.
- Intermediate data_out values in SHIFT are visible but not valid results.

## Timing
- Reset (asynchronous, immediate): state=IDLE, cnt=0, data_out=0, carry_out=0, busy=0, done=0.
- Reset during SHIFT or DONE aborts the operation; no done pulse is issued.
- start accepted at edge k:
  - busy=1 from edge k to edge k+N+1, where N=amount.
  - Shifts occur at edges k+1 … k+N.
  - done=1 from edge k+N+1 to edge k+N+2.
- Latency from accepting edge to done = N+1 cycles. amount=0 gives done after 1 cycle.
- busy and done are never high together.
- Earliest next accept: edge k+N+2, on a start held in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 mid-cycle with random inputs. Required: data_out=12'h000, carry_out=0, busy=0, done=0, asynchronously.
- LSL: data_in=12'h0F3, amount=4, mode=000. Required: busy for 5 cycles, then done for 1 cycle, data_out=12'hF30, carry_out=0.
- Right shifts:
  - ASR with data_in=12'h800, amount=3. Required: data_out=12'hF00, carry_out=0.
  - LSR with data_in=12'h801, amount=1. Required: data_out=12'h400, carry_out=1, done 2 cycles after accept.
- Rotate wrap: ROR with data_in=12'h001, amount=13. Required: data_out=12'h800, carry_out=1, done 14 cycles after accept.
  - ROL with data_in=12'h800, amount=1. Required: data_out=12'h001.
- amount=0 and reserved mode 110 with data_in=12'hABC. Required: data_out=12'hABC, carry_out=0, done 1 cycle after accept.
  - A start pulse during busy must be ignored: no second done, result unchanged.
- Abort: reset at the 3rd cycle of an LSL-by-8. Required: outputs zero and no done. A following LSL of 12'h001 by 2 then gives 12'h004.

Source files
------------

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter, one bit position per clock, busy/done handshake
module seq_shift_unit #(
  parameter int DATA_LENGTH = 12,
  parameter int SHAMT_W     = $clog2(DATA_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2:0]             mode,
  input  logic [SHAMT_W-1:0]     amount,
  input  logic [DATA_LENGTH-1:0] data_in,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SHAMT_W-1:0]     r_cnt;
  logic [2:0]             r_mode;
  logic [DATA_LENGTH-1:0] r_data;
  logic                   r_carry;
  logic [DATA_LENGTH-1:0] w_step_data;
  logic                   w_step_carry;
  logic                   w_reserved;

  // Reserved modes collapse to a zero-step operation at capture time.
  assign w_reserved = (mode > MODE_ROR);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: SHIFT leaves only once the step counter has run out.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Single-bit step of the working register for the captured mode.
  always_comb begin
    w_step_data  = r_data;
    w_step_carry = r_carry;
    case (r_mode)
      MODE_LSL: begin
        w_step_data  = {r_data[DATA_LENGTH-2:0], 1'b0};
        w_step_carry = r_data[DATA_LENGTH-1];
      end
      MODE_LSR: begin
        w_step_data  = {1'b0, r_data[DATA_LENGTH-1:1]};
        w_step_carry = r_data[0];
      end
      MODE_ASR: begin
        w_step_data  = {r_data[DATA_LENGTH-1], r_data[DATA_LENGTH-1:1]};
        w_step_carry = r_data[0];
      end
      MODE_ROL: begin
        w_step_data  = {r_data[DATA_LENGTH-2:0], r_data[DATA_LENGTH-1]};
        w_step_carry = r_data[DATA_LENGTH-1];
      end
      MODE_ROR: begin
        w_step_data  = {r_data[0], r_data[DATA_LENGTH-1:1]};
        w_step_carry = r_data[0];
      end
      default: begin
        w_step_data  = r_data;
        w_step_carry = r_carry;
      end
    endcase
  end

  // Datapath: capture on accepted start, then one step per SHIFT cycle until the count is exhausted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_mode  <= '0;
      r_data  <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_data  <= data_in;
            r_mode  <= mode;
            r_cnt   <= w_reserved ? '0 : amount;
            r_carry <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_data  <= w_step_data;
            r_carry <= w_step_carry;
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign data_out  = r_data;
  assign carry_out = r_carry;

endmodule
